// File: rtl/sdram_port_arbiter_if.sv
// Requester-side port of sdram_port_arbiter: a held request, its payload and the completion handshake.
interface sdram_port_arbiter_if;
  logic        req;
  logic        we;
  logic [23:0] addr;
  logic [15:0] din;
  logic        uds;
  logic        lds;
  logic        ack;
  logic [15:0] dout;

  modport master (output req, we, addr, din, uds, lds, input ack, dout);
  modport slave  (input req, we, addr, din, uds, lds, output ack, dout);
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter (CPU priority, DMA anti-starvation) in front of a 68k-style SDRAM controller port.
// Optional build macro SDRAM_ARB_REFRESH_EN: internal refresh divider instead of echoing refresh_in_i.
module sdram_port_arbiter #(
  parameter int MIN_HOLD    = 2,
  parameter int GAP         = 1,
  parameter int P1_MAX_WAIT = 16,
  parameter int REFRESH_DIV = 500
) (
  input  logic                clk,
  input  logic                reset,
  sdram_port_arbiter_if.slave p0,
  sdram_port_arbiter_if.slave p1,
  output logic [23:0]         mem_addr_o,
  output logic [15:0]         mem_din_o,
  output logic                mem_uds_o,
  output logic                mem_lds_o,
  output logic                mem_oe_o,
  output logic                mem_we_o,
  input  logic [15:0]         mem_dout_i,
  input  logic                mem_dtack_i,
  input  logic                refresh_in_i,
  output logic                mem_refresh_o
);

  localparam int CW = $clog2(((MIN_HOLD > GAP) ? MIN_HOLD : GAP) + 1);

  if (MIN_HOLD < 1 || GAP < 1 || P1_MAX_WAIT > 255 || REFRESH_DIV < 2) begin : g_badParams
    $error("sdram_port_arbiter: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RELEASE
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            owner_q;
  logic [7:0]      starve_q;
  logic [7:0]      starve_d;
  logic [23:0]     memAddr_q;
  logic [15:0]     memDin_q;
  logic            memUds_q;
  logic            memLds_q;
  logic            memOe_q;
  logic            memWe_q;
  logic            ack0_q;
  logic            ack1_q;
  logic [15:0]     dout0_q;
  logic [15:0]     dout1_q;
  logic            refresh_q;

  logic            grant0;
  logic            grant1;
  logic            selWe;
  logic [23:0]     selAddr;
  logic [15:0]     selDin;
  logic            selUds;
  logic            selLds;

  // Port 0 wins by default; a port 1 that has waited long enough outranks it.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == ST_IDLE) begin
      if (p1.req && (starve_q >= 8'(P1_MAX_WAIT) || !p0.req)) begin
        grant1 = 1'b1;
      end else if (p0.req) begin
        grant0 = 1'b1;
      end
    end
  end

  always_comb begin
    selWe   = grant1 ? p1.we   : p0.we;
    selAddr = grant1 ? p1.addr : p0.addr;
    selDin  = grant1 ? p1.din  : p0.din;
    selUds  = grant1 ? p1.uds  : p0.uds;
    selLds  = grant1 ? p1.lds  : p0.lds;
  end

  always_comb begin
    starve_d = starve_q;
    if (!p1.req || grant1) begin
      starve_d = '0;
    end else if (starve_q != 8'hFF) begin
      starve_d = starve_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      owner_q   <= 1'b0;
      starve_q  <= '0;
      memAddr_q <= '0;
      memDin_q  <= '0;
      memUds_q  <= 1'b0;
      memLds_q  <= 1'b0;
      memOe_q   <= 1'b0;
      memWe_q   <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      dout0_q   <= '0;
      dout1_q   <= '0;
    end else begin
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      starve_q <= starve_d;
      case (state_q)
        ST_IDLE: begin
          if (grant0 || grant1) begin
            owner_q   <= grant1;
            memAddr_q <= selAddr;
            memDin_q  <= selDin;
            memUds_q  <= selUds;
            memLds_q  <= selLds;
            memOe_q   <= !selWe;
            memWe_q   <= selWe;
            cnt_q     <= '0;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Give the controller time to pull dtack low before we start trusting it.
          if (cnt_q == CW'(MIN_HOLD - 1)) begin
            cnt_q   <= '0;
            state_q <= ST_WAIT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_WAIT: begin
          if (mem_dtack_i) begin
            if (!memWe_q) begin
              if (owner_q) dout1_q <= mem_dout_i;
              else         dout0_q <= mem_dout_i;
            end
            if (owner_q) ack1_q <= 1'b1;
            else         ack0_q <= 1'b1;
            memOe_q  <= 1'b0;
            memWe_q  <= 1'b0;
            memUds_q <= 1'b0;
            memLds_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (cnt_q == CW'(GAP - 1)) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef SDRAM_ARB_REFRESH_EN
  localparam int RW = $clog2(REFRESH_DIV);
  logic [RW-1:0] refCnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      refCnt_q  <= '0;
      refresh_q <= 1'b0;
    end else if (refCnt_q == RW'(REFRESH_DIV - 1)) begin
      refCnt_q  <= '0;
      refresh_q <= 1'b1;
    end else begin
      refCnt_q  <= refCnt_q + RW'(1);
      refresh_q <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) refresh_q <= 1'b0;
    else       refresh_q <= refresh_in_i;
  end
`endif

  assign mem_addr_o    = memAddr_q;
  assign mem_din_o     = memDin_q;
  assign mem_uds_o     = memUds_q;
  assign mem_lds_o     = memLds_q;
  assign mem_oe_o      = memOe_q;
  assign mem_we_o      = memWe_q;
  assign mem_refresh_o = refresh_q;
  assign p0.ack        = ack0_q;
  assign p0.dout       = dout0_q;
  assign p1.ack        = ack1_q;
  assign p1.dout       = dout1_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a small dtack-dropping controller model.
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] mem_addr_o;
  logic [15:0] mem_din_o;
  logic        mem_uds_o;
  logic        mem_lds_o;
  logic        mem_oe_o;
  logic        mem_we_o;
  logic [15:0] mem_dout_i;
  logic        mem_dtack_i = 1'b1;
  logic        refresh_in_i;
  logic        mem_refresh_o;

  int vecCount  = 0;
  int missCount = 0;
  int dtackLow  = 0;

  sdram_port_arbiter_if p0If();
  sdram_port_arbiter_if p1If();

  sdram_port_arbiter #(
    .MIN_HOLD(2), .GAP(1), .P1_MAX_WAIT(16), .REFRESH_DIV(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .p0(p0If.slave),
    .p1(p1If.slave),
    .mem_addr_o(mem_addr_o),
    .mem_din_o(mem_din_o),
    .mem_uds_o(mem_uds_o),
    .mem_lds_o(mem_lds_o),
    .mem_oe_o(mem_oe_o),
    .mem_we_o(mem_we_o),
    .mem_dout_i(mem_dout_i),
    .mem_dtack_i(mem_dtack_i),
    .refresh_in_i(refresh_in_i),
    .mem_refresh_o(mem_refresh_o)
  );

  always #5 clk = ~clk;

  // Controller model: dtack drops for dtackLow cycles once it sees a new oe/we, idles high otherwise.
  int lowLeft = 0;
  bit seen    = 1'b0;
  always @(posedge clk) begin
    if (!(mem_oe_o || mem_we_o)) begin
      seen = 1'b0;
      lowLeft = 0;
      mem_dtack_i <= 1'b1;
    end else if (!seen) begin
      seen = 1'b1;
      lowLeft = dtackLow;
      mem_dtack_i <= (dtackLow == 0);
    end else if (lowLeft > 1) begin
      lowLeft = lowLeft - 1;
    end else begin
      lowLeft = 0;
      mem_dtack_i <= 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int port, input logic we, input logic [23:0] addr,
                               input logic [15:0] din, input logic uds, input logic lds);
    if (port == 0) begin
      p0If.we = we; p0If.addr = addr; p0If.din = din; p0If.uds = uds; p0If.lds = lds; p0If.req = 1'b1;
    end else begin
      p1If.we = we; p1If.addr = addr; p1If.din = din; p1If.uds = uds; p1If.lds = lds; p1If.req = 1'b1;
    end
  endtask

  task automatic dropReq(input int port);
    if (port == 0) p0If.req = 1'b0;
    else           p1If.req = 1'b0;
  endtask

  // Returns the index of the first negedge (0 = the current cycle) at which the port acks, -1 on timeout.
  task automatic waitAck(input int port, input int limit, output int lat);
    lat = -1;
    for (int i = 0; i <= limit; i++) begin
      @(negedge clk);
      if ((port == 0 && p0If.ack) || (port == 1 && p1If.ack)) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int n0;
    int n1;
    int first;
    int pulses;

    reset = 1'b1;
    refresh_in_i = 1'b0;
    mem_dout_i = 16'h0000;
    p0If.req = 1'b0; p0If.we = 1'b0; p0If.addr = '0; p0If.din = '0; p0If.uds = 1'b0; p0If.lds = 1'b0;
    p1If.req = 1'b0; p1If.we = 1'b0; p1If.addr = '0; p1If.din = '0; p1If.uds = 1'b0; p1If.lds = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_oe", 32'(mem_oe_o), 32'h0);
    checkOutput("rst_we", 32'(mem_we_o), 32'h0);
    checkOutput("rst_addr", 32'(mem_addr_o), 32'h0);
    checkOutput("rst_ack0", 32'(p0If.ack), 32'h0);
    checkOutput("rst_ack1", 32'(p1If.ack), 32'h0);
    checkOutput("rst_dout0", 32'(p0If.dout), 32'h0);
    checkOutput("rst_refresh", 32'(mem_refresh_o), 32'h0);

    // Refresh path, starting in the first cycle after reset is released.
    @(posedge clk); #1;
    reset = 1'b0;
`ifdef SDRAM_ARB_REFRESH_EN
    first = -1;
    pulses = 0;
    for (int i = 0; i <= 30; i++) begin
      @(negedge clk);
      if (mem_refresh_o) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    checkOutput("ref_first", 32'(first), 32'd10);
    checkOutput("ref_count", 32'(pulses), 32'd3);
`else
    refresh_in_i = 1'b1;
    @(negedge clk);
    checkOutput("ref_echo_c0", 32'(mem_refresh_o), 32'h0);
    @(posedge clk); #1;
    refresh_in_i = 1'b0;
    @(negedge clk);
    checkOutput("ref_echo_c1", 32'(mem_refresh_o), 32'h1);
    @(negedge clk);
    checkOutput("ref_echo_c2", 32'(mem_refresh_o), 32'h0);
`endif

    // p0 read with dtack low 3 cycles.
    @(posedge clk); #1;
    dtackLow = 3;
    mem_dout_i = 16'hBEEF;
    applyStimulus(0, 1'b0, 24'h000100, 16'h0000, 1'b1, 1'b1);
    waitAck(0, 20, lat);
    dropReq(0);
    checkOutput("rd_lat", 32'(lat), 32'd6);
    checkOutput("rd_dout", 32'(p0If.dout), 32'hBEEF);
    checkOutput("rd_oe_ack_cycle", 32'(mem_oe_o), 32'h0);
    @(negedge clk);
    checkOutput("rd_single_ack", 32'(p0If.ack), 32'h0);
    checkOutput("rd_gap_oe", 32'(mem_oe_o), 32'h0);

    // p0 write: strobes and data reach the controller, ack at cycle 4.
    @(posedge clk); #1;
    dtackLow = 0;
    applyStimulus(0, 1'b1, 24'h000200, 16'h1234, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("wr_we", 32'(mem_we_o), 32'h1);
    checkOutput("wr_oe", 32'(mem_oe_o), 32'h0);
    checkOutput("wr_uds", 32'(mem_uds_o), 32'h1);
    checkOutput("wr_lds", 32'(mem_lds_o), 32'h0);
    checkOutput("wr_din", 32'(mem_din_o), 32'h1234);
    checkOutput("wr_addr", 32'(mem_addr_o), 32'h000200);
    waitAck(0, 20, lat);
    dropReq(0);
    checkOutput("wr_lat", 32'(lat + 2), 32'd4);
    checkOutput("wr_dout_kept", 32'(p0If.dout), 32'hBEEF);

    // p1 cache-hit read: dtack never drops.
    @(posedge clk); #1;
    mem_dout_i = 16'hCAFE;
    applyStimulus(1, 1'b0, 24'h000300, 16'h0000, 1'b1, 1'b1);
    waitAck(1, 20, lat);
    dropReq(1);
    checkOutput("hit_lat", 32'(lat), 32'd4);
    checkOutput("hit_dout1", 32'(p1If.dout), 32'hCAFE);
    checkOutput("hit_dout0_kept", 32'(p0If.dout), 32'hBEEF);

    // Contention: p0 re-requests continuously, p1 must get in once starved for 16 cycles.
    @(posedge clk); #1;
    mem_dout_i = 16'h1111;
    applyStimulus(0, 1'b0, 24'h000400, 16'h0000, 1'b1, 1'b1);
    applyStimulus(1, 1'b0, 24'h000500, 16'h0000, 1'b1, 1'b1);
    n0 = 0;
    lat = -1;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      if (p0If.ack) n0++;
      if (p1If.ack) begin
        lat = i;
        break;
      end
    end
    dropReq(0);
    dropReq(1);
    checkOutput("cont_p0_acks", 32'(n0), 32'd4);
    checkOutput("cont_p1_lat", 32'(lat), 32'd24);
    checkOutput("cont_p1_dout", 32'(p1If.dout), 32'h1111);

    // Reset while waiting on dtack, with p0 still requesting.
    @(posedge clk); #1;
    dtackLow = 10;
    mem_dout_i = 16'h5A5A;
    applyStimulus(0, 1'b0, 24'h000600, 16'h0000, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    dtackLow = 0;
    @(negedge clk);
    checkOutput("rst_wait_oe_before", 32'(mem_oe_o), 32'h1);
    checkOutput("rst_wait_no_ack_pre", 32'(p0If.ack), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_wait_oe_drop", 32'(mem_oe_o), 32'h0);
    checkOutput("rst_wait_no_ack", 32'(p0If.ack), 32'h0);
    checkOutput("rst_wait_dout_clr", 32'(p0If.dout), 32'h0);
    @(negedge clk);
    checkOutput("rst_wait_regrant", 32'(mem_oe_o), 32'h1);
    waitAck(0, 20, lat);
    dropReq(0);
    checkOutput("rst_wait_lat", 32'(lat), 32'd2);
    checkOutput("rst_wait_dout", 32'(p0If.dout), 32'h5A5A);

    // p1 withdraws while p0 is being served: no p1 ack may appear.
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 24'h000700, 16'h0000, 1'b1, 1'b1);
    applyStimulus(1, 1'b0, 24'h000800, 16'h0000, 1'b1, 1'b1);
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 1) dropReq(1);
      if (p0If.ack) begin
        n0++;
        dropReq(0);
      end
      if (p1If.ack) n1++;
    end
    checkOutput("wd_p0_acks", 32'(n0), 32'd1);
    checkOutput("wd_p1_acks", 32'(n1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
